simon_seq_ctrl: RTL and testbench

//  Game sequencer for Simon Says. Captures the 32-bit seed from the free-running seed generator on start.

---
 rtl/simon_seq_ctrl_pkg.sv | 23 ++
 rtl/simon_seq_ctrl_cycle_timer.sv | 35 +++
 rtl/simon_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_simon_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_seq_ctrl_pkg.sv
// Shared types and helpers for the Simon Says game sequencer.
package simon_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShowOn,
        StShowOff,
        StWaitIn,
        StWin,
        StFail
    } seq_state_t;

    typedef logic [1:0] color_t;

    localparam int unsigned MAX_PATTERN = 16;
    localparam int unsigned IDX_W       = $clog2(MAX_PATTERN);

    // Colour i of the pattern lives in seed bits [2i+1:2i].
    function automatic color_t seed_color(input logic [31:0] s, input logic [IDX_W-1:0] idx);
        return s[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/simon_seq_ctrl_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Reload has priority; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon Says sequencer: plays a growing colour pattern taken from a captured
// seed, then checks the player's presses against it round by round.
module simon_seq_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000,
    parameter int unsigned IN_TIMEOUT = 250_000_000,
    parameter int unsigned MAX_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    input  logic        start,
    input  logic        btn_valid,
    input  logic [1:0]  btn_color,
    output logic        led_on,
    output logic [1:0]  led_color,
    output logic [4:0]  round,
    output logic        busy,
    output logic        win,
    output logic        fail,
    output logic        seed_rst
);

    localparam int unsigned MaxOnOff  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned MaxCycles = (MaxOnOff > IN_TIMEOUT) ? MaxOnOff : IN_TIMEOUT;
    localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

    // Timer load values: a phase of N cycles loads N-1 and ends when done.
    localparam logic [TimerW-1:0] OnLoad  = TimerW'(ON_CYCLES - 1);
    localparam logic [TimerW-1:0] OffLoad = TimerW'(OFF_CYCLES - 1);
    localparam logic [TimerW-1:0] InLoad  = TimerW'(IN_TIMEOUT - 1);

    seq_state_t         state_q, state_d;
    logic [31:0]        seed_q, seed_d;
    logic [4:0]         round_q, round_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gap_q, gap_d;
    logic               led_on_q, led_on_d;
    color_t             led_color_q, led_color_d;
    logic               busy_q, busy_d;
    logic               win_q, win_d;
    logic               fail_q, fail_d;
    logic               seed_rst_q, seed_rst_d;

    logic               t_load;
    logic [TimerW-1:0]  t_val;
    logic               t_done;
    logic [4:0]         idx_inc;
    logic               press_ok;

    assign idx_inc  = {1'b0, idx_q} + 5'd1;
    assign press_ok = (btn_color == seed_color(seed_q, idx_q));

    cycle_timer #(
        .WIDTH (TimerW)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (t_load),
        .load_val_i (t_val),
        .done_o     (t_done)
    );

    // Next-state logic; every state change reloads the shared timer.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        round_d = round_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        t_load  = 1'b0;
        t_val   = '0;
        unique case (state_q)
            StIdle, StWin, StFail: begin
                if (start) begin
                    seed_d  = seed;
                    round_d = 5'd1;
                    idx_d   = '0;
                    gap_d   = 1'b0;
                    state_d = StShowOn;
                    t_load  = 1'b1;
                    t_val   = OnLoad;
                end
            end
            StShowOn: begin
                if (t_done) begin
                    state_d = StShowOff;
                    t_load  = 1'b1;
                    t_val   = OffLoad;
                end
            end
            StShowOff: begin
                if (t_done) begin
                    t_load = 1'b1;
                    if (gap_q) begin
                        // Inter-round gap: replay starts from colour 0.
                        gap_d   = 1'b0;
                        state_d = StShowOn;
                        t_val   = OnLoad;
                    end else if (idx_inc == round_q) begin
                        idx_d   = '0;
                        state_d = StWaitIn;
                        t_val   = InLoad;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StShowOn;
                        t_val   = OnLoad;
                    end
                end
            end
            StWaitIn: begin
                // A press beats the timeout on the same cycle.
                if (btn_valid) begin
                    if (press_ok) begin
                        t_load = 1'b1;
                        t_val  = InLoad;
                        if (idx_inc < round_q) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else if (round_q == 5'(MAX_ROUNDS)) begin
                            state_d = StWin;
                        end else begin
                            round_d = round_q + 5'd1;
                            idx_d   = '0;
                            gap_d   = 1'b1;
                            state_d = StShowOff;
                            t_val   = OffLoad;
                        end
                    end else begin
                        state_d = StFail;
                    end
                end else if (t_done) begin
                    state_d = StFail;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output values derived from the upcoming state so they can be registered.
    always_comb begin
        led_on_d    = (state_d == StShowOn);
        led_color_d = led_on_d ? seed_color(seed_d, idx_d) : 2'b00;
        busy_d      = (state_d == StShowOn) || (state_d == StShowOff) || (state_d == StWaitIn);
        win_d       = (state_d == StWin);
        fail_d      = (state_d == StFail);
        seed_rst_d  = (win_d || fail_d) && (state_d != state_q);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            seed_q      <= '0;
            round_q     <= '0;
            idx_q       <= '0;
            gap_q       <= 1'b0;
            led_on_q    <= 1'b0;
            led_color_q <= 2'b00;
            busy_q      <= 1'b0;
            win_q       <= 1'b0;
            fail_q      <= 1'b0;
            seed_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            round_q     <= round_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            led_on_q    <= led_on_d;
            led_color_q <= led_color_d;
            busy_q      <= busy_d;
            win_q       <= win_d;
            fail_q      <= fail_d;
            seed_rst_q  <= seed_rst_d;
        end
    end

    assign led_on    = led_on_q;
    assign led_color = led_color_q;
    assign round     = round_q;
    assign busy      = busy_q;
    assign win       = win_q;
    assign fail      = fail_q;
    assign seed_rst  = seed_rst_q;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Bench for simon_seq_ctrl: scripted game play with random seeds, delays,
// wrong presses and noise; expected output frames go to a scoreboard queue.
module tb_simon_seq_ctrl;

    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int TO   = 10;
    localparam int MAXR = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] seed = '0;
    logic        start = 1'b0;
    logic        btn_valid = 1'b0;
    logic [1:0]  btn_color = 2'b00;
    logic        led_on;
    logic [1:0]  led_color;
    logic [4:0]  round;
    logic        busy, win, fail, seed_rst;

    always #5 clk = ~clk;

    simon_seq_ctrl #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .IN_TIMEOUT (TO),
        .MAX_ROUNDS (MAXR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seed      (seed),
        .start     (start),
        .btn_valid (btn_valid),
        .btn_color (btn_color),
        .led_on    (led_on),
        .led_color (led_color),
        .round     (round),
        .busy      (busy),
        .win       (win),
        .fail      (fail),
        .seed_rst  (seed_rst)
    );

    typedef struct packed {
        logic       led_on;
        logic [1:0] led_color;
        logic [4:0] round;
        logic       busy;
        logic       win;
        logic       fail;
        logic       seed_rst;
    } frame_t;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Game model: pattern seed, round number and final result.
    logic [31:0] m_seed = '0;
    int          m_round = 0;
    bit          m_win = 0;
    bit          m_fail = 0;
    int          abort_at = 0;
    bit          aborted = 0;

    function automatic logic [1:0] col(int i);
        logic [31:0] sh;
        sh = m_seed >> (2 * i);
        return sh[1:0];
    endfunction

    function automatic frame_t f_play(bit lit, int i);
        frame_t f;
        f = '0;
        f.led_on    = lit;
        f.led_color = lit ? col(i) : 2'b00;
        f.round     = 5'(m_round);
        f.busy      = 1'b1;
        return f;
    endfunction

    function automatic frame_t f_end(bit first);
        frame_t f;
        f = '0;
        f.round    = 5'(m_round);
        f.win      = m_win;
        f.fail     = m_fail;
        f.seed_rst = first;
        return f;
    endfunction

    // One clock of stimulus plus the outputs expected after the next edge.
    task automatic cyc(bit rst, bit st, logic [31:0] sd, bit bv, logic [1:0] bc, frame_t e);
        @(negedge clk);
        reset     = rst;
        start     = st;
        seed      = sd;
        btn_valid = bv;
        btn_color = bc;
        exp_q.push_back(e);
    endtask

    // Cycle during a game: stray starts (and presses if allowed) must be ignored.
    task automatic busy_cyc(bit allow_bv, frame_t e);
        cyc(1'b0, $urandom_range(0, 2) == 0, $urandom, allow_bv && ($urandom_range(0, 2) == 0),
            2'($urandom), e);
    endtask

    // Cycles in IDLE/WIN/FAIL with no start: outputs hold, presses ignored.
    task automatic quiet_end(int n);
        for (int j = 0; j < n; j++) begin
            cyc(1'b0, 1'b0, $urandom, $urandom_range(0, 1) == 1, 2'($urandom), f_end(1'b0));
        end
    endtask

    task automatic do_reset();
        m_round = 0;
        m_win   = 0;
        m_fail  = 0;
        aborted = 1;
        cyc(1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1, 2'($urandom),
            f_end(1'b0));
    endtask

    // Playback of colours 0..r-1, then the cycle that enters the input phase.
    task automatic play(int r, bit skip_first);
        for (int i = 0; i < r; i++) begin
            for (int c = 0; c < ON; c++) begin
                if (!(skip_first && i == 0 && c == 0)) begin
                    if (r == abort_at && i == 1 && c == 1) begin
                        do_reset();
                        return;
                    end
                    busy_cyc(1'b1, f_play(1'b1, i));
                end
            end
            for (int c = 0; c < OFF; c++) busy_cyc(1'b1, f_play(1'b0, 0));
        end
        busy_cyc(1'b1, f_play(1'b0, 0));
    endtask

    task automatic new_game(logic [31:0] s, bit with_press);
        m_seed  = s;
        m_round = 1;
        m_win   = 0;
        m_fail  = 0;
        aborted = 0;
        cyc(1'b0, 1'b1, s, with_press, 2'($urandom), f_play(1'b1, 0));
        play(1, 1'b1);
    endtask

    task automatic wait_quiet(int k);
        for (int j = 0; j < k; j++) busy_cyc(1'b0, f_play(1'b0, 0));
    endtask

    // Wait k idle cycles then press colour i xor flip (flip != 0 is a wrong press).
    task automatic answer(int i, int k, logic [1:0] flip);
        logic [1:0] bc;
        wait_quiet(k);
        bc = col(i) ^ flip;
        if (flip != 2'b00) begin
            m_fail = 1;
            cyc(1'b0, $urandom_range(0, 1) == 1, $urandom, 1'b1, bc, f_end(1'b1));
        end else if (i < m_round - 1) begin
            cyc(1'b0, $urandom_range(0, 1) == 1, $urandom, 1'b1, bc, f_play(1'b0, 0));
        end else if (m_round == MAXR) begin
            m_win = 1;
            cyc(1'b0, $urandom_range(0, 1) == 1, $urandom, 1'b1, bc, f_end(1'b1));
        end else begin
            m_round++;
            cyc(1'b0, $urandom_range(0, 1) == 1, $urandom, 1'b1, bc, f_play(1'b0, 0));
            for (int j = 0; j < OFF - 1; j++) busy_cyc(1'b1, f_play(1'b0, 0));
            play(m_round, 1'b0);
        end
    endtask

    task automatic timeout_fail();
        wait_quiet(TO - 1);
        m_fail = 1;
        cyc(1'b0, $urandom_range(0, 1) == 1, $urandom, 1'b0, 2'($urandom), f_end(1'b1));
    endtask

    // Whole game; fail_r == 0 means every press is correct.
    task automatic play_game(logic [31:0] s, int fail_r, int fail_i, bit to, bit with_press);
        new_game(s, with_press);
        while (!m_win && !m_fail && !aborted) begin
            int r;
            r = m_round;
            for (int i = 0; i < r; i++) begin
                if (r == fail_r && i == fail_i) begin
                    if (to) timeout_fail();
                    else answer(i, $urandom_range(0, TO - 1), 2'($urandom_range(1, 3)));
                    break;
                end
                answer(i, $urandom_range(0, TO - 1), 2'b00);
                if (aborted) break;
            end
        end
    endtask

    // Monitor: after each edge, pop one expected frame and compare.
    initial begin
        frame_t e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {led_on, led_color, round, busy, win, fail, seed_rst};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got led=%b col=%0d rnd=%0d busy=%b win=%b fail=%b srst=%b, want led=%b col=%0d rnd=%0d busy=%b win=%b fail=%b srst=%b",
                             $time, a.led_on, a.led_color, a.round, a.busy, a.win, a.fail,
                             a.seed_rst, e.led_on, e.led_color, e.round, e.busy, e.win, e.fail,
                             e.seed_rst);
                end
            end
        end
    end

    initial begin
        cyc(1'b1, 1'b0, '0, 1'b0, 2'b00, f_end(1'b0));
        cyc(1'b1, 1'b0, '0, 1'b0, 2'b00, f_end(1'b0));
        quiet_end(3);

        // Known pattern 0,1,2,3..: round 1, round 2 with a last-cycle press, then timeout.
        new_game(32'h1BE4_1BE4, 1'b0);
        answer(0, $urandom_range(0, TO - 1), 2'b00);
        answer(0, TO - 1, 2'b00);
        timeout_fail();
        quiet_end(4);

        // Start plus press from FAIL, then a wrong colour (2) in round 1.
        new_game(32'h1BE4_1BE4, 1'b1);
        answer(0, 2, 2'b10);
        quiet_end(4);

        // Full game to WIN.
        play_game($urandom, 0, 0, 1'b0, 1'b0);
        quiet_end(4);

        // Restart from WIN, then reset during round-3 playback.
        abort_at = 3;
        play_game($urandom, 0, 0, 1'b0, 1'b0);
        abort_at = 0;
        quiet_end(5);

        // Random games ending in wrong presses or timeouts.
        for (int g = 0; g < 8; g++) begin
            int fr;
            fr = $urandom_range(1, 6);
            play_game($urandom, fr, $urandom_range(0, fr - 1), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1);
            quiet_end(3);
        end

        play_game($urandom, 0, 0, 1'b0, 1'b1);
        quiet_end(3);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d frames left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
